// File: rtl/decoder_n_scan.sv
// decoder_n_scan: registered one-cold decoder with active-low enable and round-robin scan mode
module decoder_n_scan #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [2**SEL_W-1:0] out_n,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               wrap
);
    localparam int NUM_OUT = 2**SEL_W;
    localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
    localparam logic [SEL_W-1:0] ILAST = SEL_W'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] ONE = NUM_OUT'(1);
    logic [SEL_W-1:0] idx;
    logic [DW-1:0]    dcnt;
    logic             last;
    assign last = dcnt == DLAST;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_n   <= '1;
            cur_sel <= '0;
            wrap    <= 1'b0;
            idx     <= '0;
            dcnt    <= '0;
        end else if (enable_n) begin
            out_n <= '1;
            wrap  <= 1'b0;
        end else if (!mode) begin
            out_n   <= ~(ONE << sel);
            cur_sel <= sel;
            wrap    <= 1'b0;
        end else begin
            out_n   <= ~(ONE << idx);
            cur_sel <= idx;
            wrap    <= (idx == ILAST) && last;
            dcnt    <= last ? '0 : dcnt + 1'b1;
            idx     <= last ? idx + 1'b1 : idx;
        end
    end
endmodule
